// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the configurable UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through frame queue; a push into a full queue is dropped.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter: frame queue feeding a start/data/parity/stop
// serialiser that advances one oversample tick per clk_en.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          send,
    input  logic [DATA_BITS-1:0]          send_data,
    output logic                          tx_data,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    tx_state_t              state, state_n;
    logic [CW-1:0]          en_cnt, en_cnt_n;
    logic [IW-1:0]          bit_idx, bit_idx_n;
    logic                   stop_cnt, stop_cnt_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par, par_n;
    logic                   tx_n;
    logic                   pop;
    logic                   load;
    logic                   empty;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   fifo_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset),
        .push  (send),
        .pop   (pop),
        .wdata (send_data),
        .rdata (fifo_q),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bit_end = en_cnt == CW'(OVERSAMPLE - 1);
    assign busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            en_cnt   <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
            tx_data  <= 1'b1;
        end else begin
            state    <= state_n;
            en_cnt   <= en_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            shreg    <= shreg_n;
            par      <= par_n;
            tx_data  <= tx_n;
        end
    end

    // tx_n is the line level for the upcoming tick, so the line moves on the same edge as the state
    always_comb begin
        state_n    = state;
        en_cnt_n   = en_cnt;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shreg_n    = shreg;
        par_n      = par;
        tx_n       = tx_data;
        pop        = 1'b0;
        load       = 1'b0;
        if (clk_en) begin
            en_cnt_n = bit_end ? '0 : en_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    en_cnt_n = '0;
                    load     = !empty;
                end
                START: begin
                    if (bit_end) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                        tx_n      = shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                state_n = PARITY;
                                tx_n    = par;
                            end else begin
                                state_n    = STOP;
                                stop_cnt_n = 1'b0;
                                tx_n       = 1'b1;
                            end
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                            shreg_n   = shreg >> 1;
                            tx_n      = shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        tx_n       = 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            load = !empty;
                            if (empty) begin
                                state_n = IDLE;
                                tx_n    = 1'b1;
                            end
                        end else begin
                            stop_cnt_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
            // Pop straight into START so queued frames follow with no idle gap
            if (load) begin
                pop      = 1'b1;
                state_n  = START;
                en_cnt_n = '0;
                shreg_n  = fifo_q;
                par_n    = (PARITY_MODE == PARITY_ODD) ? ~^fifo_q : ^fifo_q;
                tx_n     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: three transmitter configurations share one clock; a
// line monitor decodes each serial stream against a frame-level model.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] en;
    logic [2:0] snd;
    logic [7:0] sd0;
    logic [6:0] sd1;
    logic [7:0] sd2;
    wire  [2:0] txv;
    wire  [2:0] busyv;
    wire  [2:0] fullv;
    wire  [2:0] cnt0;
    wire  [2:0] cnt1;
    wire  [2:0] cnt2;

    uart_tx_cfg dut0 (
        .clk_in(clk), .reset(rst[0]), .clk_en(en[0]), .send(snd[0]),
        .send_data(sd0), .tx_data(txv[0]), .busy(busyv[0]),
        .full(fullv[0]), .fifo_count(cnt0)
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
        .clk_in(clk), .reset(rst[1]), .clk_en(en[1]), .send(snd[1]),
        .send_data(sd1), .tx_data(txv[1]), .busy(busyv[1]),
        .full(fullv[1]), .fifo_count(cnt1)
    );

    uart_tx_cfg #(.PARITY_MODE(2)) dut2 (
        .clk_in(clk), .reset(rst[2]), .clk_en(en[2]), .send(snd[2]),
        .send_data(sd2), .tx_data(txv[2]), .busy(busyv[2]),
        .full(fullv[2]), .fifo_count(cnt2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int sb_q[$];
    int pos[3] = '{-1, -1, -1};
    int cur[3];
    int bad_pos[3];
    int started[3] = '{0, 0, 0};
    int acc[3] = '{0, 0, 0};
    int base[3] = '{0, 0, 0};
    int burst[3] = '{0, 0, 0};
    logic [2:0] en_s;

    function automatic int dbits(input int g);
        return (g == 1) ? 7 : 8;
    endfunction

    function automatic int sbits(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    // instance g uses parity mode g: 0 none, 1 even, 2 odd
    function automatic int frame_len(input int g);
        return (1 + dbits(g) + ((g != 0) ? 1 : 0) + sbits(g)) * 16;
    endfunction

    function automatic int ref_level(input int g, input int d, input int p);
        int b;
        int ones;
        b = p / 16;
        ones = $countones(d);
        if (b == 0) return 0;
        if (b <= dbits(g)) return (d >> (b - 1)) & 1;
        if (g != 0 && b == dbits(g) + 1) return (g == 1) ? ones % 2 : (ones + 1) % 2;
        return 1;
    endfunction

    function automatic int cnt_of(input int g);
        if (g == 0) return int'(cnt0);
        if (g == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    function automatic int model_cnt(input int g);
        return acc[g] - (started[g] - base[g]);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic mon_step(input int g, input logic s);
        int k;
        if (pos[g] < 0) begin
            if (s) return;
            pos[g] = 0;
            bad_pos[g] = -1;
            started[g]++;
            cur[g] = -1;
            k = -1;
            for (int i = 0; i < sb_q.size(); i++) begin
                if (sb_q[i] / 1024 == g) begin
                    k = i;
                    break;
                end
            end
            if (k >= 0) begin
                cur[g] = sb_q[k] % 1024;
                sb_q.delete(k);
            end
            chk($sformatf("frame_expected[%0d]", g), (k >= 0) ? 1 : 0, 1);
        end
        if (bad_pos[g] < 0 && int'(s) != ref_level(g, cur[g], pos[g]))
            bad_pos[g] = pos[g];
        pos[g]++;
        if (pos[g] == frame_len(g)) begin
            n_chk++;
            if (bad_pos[g] >= 0) begin
                n_fail++;
                $display("FAIL frame[%0d] data 0x%0h: line wrong at enable %0d, got %0d want %0d",
                         g, cur[g], bad_pos[g], 1 - ref_level(g, cur[g], bad_pos[g]),
                         ref_level(g, cur[g], bad_pos[g]));
            end
            pos[g] = -1;
        end
    endtask

    // Monitor: one line sample per enabled clock edge, taken just after the edge
    always begin
        @(posedge clk);
        en_s = en & ~rst;
        #1;
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) pos[g] = -1;
            else if (en_s[g]) mon_step(g, txv[g]);
        end
    end

    task automatic do_send(input int g, input int d);
        int v;
        v = d & ((1 << dbits(g)) - 1);
        chk($sformatf("full[%0d]", g), int'(fullv[g]), (model_cnt(g) >= 4) ? 1 : 0);
        chk($sformatf("fifo_count[%0d]", g), cnt_of(g), model_cnt(g));
        snd[g] = 1'b1;
        if (g == 0) sd0 = v[7:0];
        else if (g == 1) sd1 = v[6:0];
        else sd2 = v[7:0];
        if (model_cnt(g) < 4) begin
            sb_q.push_back(g * 1024 + v);
            acc[g]++;
        end
    endtask

    task automatic wait_idle(input int g, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            snd[g] = 1'b0;
            n++;
        end while (busyv[g] && n < budget);
    endtask

    initial begin
        int n;
        rst = 3'b111;
        en = 3'b000;
        snd = 3'b000;
        sd0 = '0;
        sd1 = '0;
        sd2 = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_tx[%0d]", g), int'(txv[g]), 1);
            chk($sformatf("rst_busy[%0d]", g), int'(busyv[g]), 0);
            chk($sformatf("rst_full[%0d]", g), int'(fullv[g]), 0);
            chk($sformatf("rst_count[%0d]", g), cnt_of(g), 0);
        end
        rst = 3'b000;
        en = 3'b111;

        @(negedge clk);
        do_send(0, 'hA5);
        wait_idle(0, 400, n);
        chk("busy_len_a5", n, 2 + 160);

        @(negedge clk);
        do_send(1, 'h41);
        wait_idle(1, 400, n);
        chk("busy_len_41", n, 2 + 176);

        @(negedge clk);
        do_send(2, 'hFF);
        wait_idle(2, 400, n);
        chk("busy_len_ff", n, 2 + 176);
        @(negedge clk);
        do_send(2, 'hFE);
        wait_idle(2, 400, n);
        chk("busy_len_fe", n, 2 + 176);

        // Fill the queue with the serialiser stalled, then release it
        en[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            do_send(0, i);
        end
        @(negedge clk);
        snd[0] = 1'b0;
        chk("stalled_full", int'(fullv[0]), 1);
        chk("stalled_count", cnt_of(0), 4);
        en[0] = 1'b1;
        wait_idle(0, 1000, n);
        chk("backlog_len", n, 1 + 4 * 160);

        // Reset in the middle of a frame with two entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            do_send(0, 'h11 * (i + 1));
        end
        @(negedge clk);
        snd[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_reset_count", cnt_of(0), 2);
        rst[0] = 1'b1;
        #1;
        chk("abort_tx", int'(txv[0]), 1);
        chk("abort_count", cnt_of(0), 0);
        chk("abort_busy", int'(busyv[0]), 0);
        for (int i = sb_q.size() - 1; i >= 0; i--)
            if (sb_q[i] / 1024 == 0) sb_q.delete(i);
        acc[0] = 0;
        base[0] = started[0];
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        do_send(0, 'h5A);
        wait_idle(0, 400, n);
        chk("post_reset_len", n, 2 + 160);

        // Random traffic with random enable gaps on all three instances
        repeat (6000) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                snd[g] = 1'b0;
                en[g] = ($urandom_range(0, 3) != 0);
                if (burst[g] == 0 && $urandom_range(0, 299) == 0)
                    burst[g] = $urandom_range(1, 6);
                if (burst[g] > 0) begin
                    burst[g]--;
                    do_send(g, $urandom_range(0, 255));
                end
            end
        end
        @(negedge clk);
        snd = 3'b000;
        en = 3'b111;
        n = 0;
        while (busyv != 3'b000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", int'(busyv), 0);
        repeat (4) @(negedge clk);
        chk("leftover_frames", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
